// File: rtl/multi_button_event_decoder_pkg.sv
// Shared types and helpers for the button event decoder: FSM state encoding
// and the one-hot classifier used on the debounced button vector.
package button_events_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHORT,
    ST_LONG,
    ST_LOCK
  } t_bed_state;

  // True when exactly one of the four bits is set.
  function automatic logic f_is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/multi_button_event_decoder_if.sv
// Bundle of the debounced button levels and the decoded event outputs.
// Events are single-cycle pulses with no backpressure: the consumer must take
// each pulse in the cycle it is high; there is no valid/ready pair.
interface multi_button_event_decoder_if;
  logic [3:0] btns_deb;
  logic [3:0] btns_press;
  logic [3:0] btns_release;
  logic [3:0] btns_long;
  logic [3:0] btns_repeat;
  logic [3:0] btns_held;

  modport master (
    output btns_deb,
    input  btns_press, btns_release, btns_long, btns_repeat, btns_held
  );

  modport slave (
    input  btns_deb,
    output btns_press, btns_release, btns_long, btns_repeat, btns_held
  );
endinterface

// File: rtl/multi_button_event_decoder.sv
// Decodes a mutually-exclusive debounced button vector into registered
// one-cycle press, release, long-press and auto-repeat pulses.
module multi_button_event_decoder
  import button_events_pkg::*;
#(
  parameter int FCLK      = 20000000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 250
) (
  input  logic       i_clk_mhz,
  input  logic       i_rst_mhz,
  input  logic [3:0] i_btns_deb,
  output logic [3:0] o_btns_press,
  output logic [3:0] o_btns_release,
  output logic [3:0] o_btns_long,
  output logic [3:0] o_btns_repeat,
  output logic [3:0] o_btns_held
);

  // 64-bit arithmetic: FCLK*LONG_MS overflows 32 bits at real clock rates.
  localparam longint c_long_tmax = (longint'(FCLK) * longint'(LONG_MS)) / 1000 - 1;
  localparam longint c_rep_tmax  = (longint'(FCLK) * longint'(REPEAT_MS)) / 1000 - 1;
  localparam longint c_tmax      = (c_long_tmax > c_rep_tmax) ? c_long_tmax : c_rep_tmax;
  localparam int     TW          = (c_tmax < 1) ? 1 : $clog2(c_tmax + 1);

  localparam logic [TW-1:0] c_long_lim = TW'(c_long_tmax);
  localparam logic [TW-1:0] c_rep_lim  = TW'(c_rep_tmax);

  t_bed_state    r_state;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_held;
  logic [3:0]    r_press;
  logic [3:0]    r_release;
  logic [3:0]    r_long;
  logic [3:0]    r_repeat;

  logic w_zero;
  logic w_valid;
  logic w_invalid;
  logic w_same;

  assign w_zero    = (i_btns_deb == 4'd0);
  assign w_valid   = f_is_onehot4(i_btns_deb);
  assign w_invalid = !w_zero && !w_valid;
  assign w_same    = (i_btns_deb == r_held);

  always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
    if (i_rst_mhz) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_held    <= 4'd0;
      r_press   <= 4'd0;
      r_release <= 4'd0;
      r_long    <= 4'd0;
      r_repeat  <= 4'd0;
    end else begin
      r_press   <= 4'd0;
      r_release <= 4'd0;
      r_long    <= 4'd0;
      r_repeat  <= 4'd0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_press <= i_btns_deb;
            r_held  <= i_btns_deb;
            r_timer <= '0;
            r_state <= ST_SHORT;
          end else if (w_invalid) begin
            r_state <= ST_LOCK;
          end
        end

        // Input changes take priority over timer thresholds in the same cycle.
        ST_SHORT, ST_LONG: begin
          if (w_zero) begin
            r_release <= r_held;
            r_held    <= 4'd0;
            r_state   <= ST_IDLE;
          end else if (w_invalid) begin
            r_release <= r_held;
            r_held    <= 4'd0;
            r_state   <= ST_LOCK;
          end else if (!w_same) begin
            r_release <= r_held;
            r_press   <= i_btns_deb;
            r_held    <= i_btns_deb;
            r_timer   <= '0;
            r_state   <= ST_SHORT;
          end else if (r_state == ST_SHORT) begin
            if (r_timer == c_long_lim) begin
              r_long  <= r_held;
              r_timer <= '0;
              r_state <= ST_LONG;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end else begin
            if (r_timer == c_rep_lim) begin
              r_repeat <= r_held;
              r_timer  <= '0;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
        end

        ST_LOCK: begin
          if (w_zero) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_held  <= 4'd0;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign o_btns_press   = r_press;
  assign o_btns_release = r_release;
  assign o_btns_long    = r_long;
  assign o_btns_repeat  = r_repeat;
  assign o_btns_held    = r_held;

endmodule

// File: tb/tb_multi_button_event_decoder.sv
// Bench for multi_button_event_decoder: directed scenarios with literal
// timing expectations plus randomized button traffic against a cycle model.
module tb_multi_button_event_decoder;

  localparam int FCLK      = 20000;
  localparam int LONG_MS   = 10;
  localparam int REPEAT_MS = 5;
  localparam int LONG_N    = FCLK * LONG_MS / 1000;    // cycles press -> long
  localparam int REP_N     = FCLK * REPEAT_MS / 1000;  // cycles between repeats
  localparam int W         = 20;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_button_event_decoder_if bus ();

  multi_button_event_decoder #(
    .FCLK      (FCLK),
    .LONG_MS   (LONG_MS),
    .REPEAT_MS (REPEAT_MS)
  ) dut (
    .i_clk_mhz      (clk),
    .i_rst_mhz      (rst),
    .i_btns_deb     (bus.btns_deb),
    .o_btns_press   (bus.btns_press),
    .o_btns_release (bus.btns_release),
    .o_btns_long    (bus.btns_long),
    .o_btns_repeat  (bus.btns_repeat),
    .o_btns_held    (bus.btns_held)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the held button and its age in cycles since the
  // press was accepted; events follow from the age, not from a timer.
  logic [W-1:0] exp_q[$];
  logic [3:0]   m_held    = 4'd0;
  int           m_age     = 0;
  bit           m_lock    = 1'b0;
  bit           m_started = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic [3:0] in_v, p, r, l, rp;
    p = 4'd0; r = 4'd0; l = 4'd0; rp = 4'd0;
    m_started = 1'b1;
    if (rst) begin
      m_held = 4'd0;
      m_age  = 0;
      m_lock = 1'b0;
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      in_v = bus.btns_deb;
      if (m_lock) begin
        if (in_v == 4'd0) m_lock = 1'b0;
      end else if (m_held == 4'd0) begin
        if ($countones(in_v) == 1) begin
          p = in_v; m_held = in_v; m_age = 0;
        end else if (in_v != 4'd0) begin
          m_lock = 1'b1;
        end
      end else begin
        if (in_v == 4'd0) begin
          r = m_held; m_held = 4'd0;
        end else if ($countones(in_v) > 1) begin
          r = m_held; m_held = 4'd0; m_lock = 1'b1;
        end else if (in_v != m_held) begin
          r = m_held; p = in_v; m_held = in_v; m_age = 0;
        end else begin
          m_age++;
          if (m_age == LONG_N) l = m_held;
          else if (m_age > LONG_N && (m_age - LONG_N) % REP_N == 0) rp = m_held;
        end
      end
      exp_q.push_back({p, r, l, rp, m_held});
    end
  end

  // Scoreboard: every falling edge compares all outputs with the model.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (m_started) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL model_queue: got empty queue, required one entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check4("press",   bus.btns_press,   e[19:16]);
        check4("release", bus.btns_release, e[15:12]);
        check4("long",    bus.btns_long,    e[11:8]);
        check4("repeat",  bus.btns_repeat,  e[7:4]);
        check4("held",    bus.btns_held,    e[3:0]);
      end
    end
  end

  // Driver tasks (inputs change on falling edges)
  task automatic set_in(input logic [3:0] v);
    bus.btns_deb = v;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [3:0] sel_out(input int kind);
    case (kind)
      0:       return bus.btns_press;
      1:       return bus.btns_release;
      2:       return bus.btns_long;
      default: return bus.btns_repeat;
    endcase
  endfunction

  // Wait for the next pulse of one event kind; check its value and how many
  // falling edges after the call it appeared.
  task automatic wait_evt(input string name, input int kind, input logic [3:0] exp_v,
                          input int exp_n);
    bit seen = 1'b0;
    for (int k = 1; k <= exp_n + 20; k++) begin
      @(negedge clk);
      if (sel_out(kind) != 4'd0) begin
        check4({name, "_value"}, sel_out(kind), exp_v);
        n_checks++;
        if (k != exp_n) begin
          n_errors++;
          $display("FAIL %s_latency: got %0d cycles expected %0d", name, k, exp_n);
        end
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no pulse within %0d cycles, expected %b", name,
               exp_n + 20, exp_v);
    end
  endtask

  initial begin
    int seg_cls, seg_len;
    logic [3:0] v;

    rst = 1'b1;
    bus.btns_deb = 4'd0;
    cycles(3);
    check4("reset_held", bus.btns_held, 4'd0);
    check4("reset_press", bus.btns_press, 4'd0);
    rst = 1'b0;
    cycles(2);

    // Short press: no long pulse, release one cycle after the fall.
    set_in(4'b0001);
    wait_evt("s1_press", 0, 4'b0001, 1);
    check4("s1_held", bus.btns_held, 4'b0001);
    cycles(49);
    set_in(4'b0000);
    wait_evt("s1_release", 1, 4'b0001, 1);
    cycles(3);

    // Long hold with two repeats; release lands on a repeat boundary.
    set_in(4'b0100);
    wait_evt("s2_press", 0, 4'b0100, 1);
    wait_evt("s2_long", 2, 4'b0100, 200);
    wait_evt("s2_rep1", 3, 4'b0100, 100);
    wait_evt("s2_rep2", 3, 4'b0100, 100);
    cycles(99);
    set_in(4'b0000);
    wait_evt("s2_release", 1, 4'b0100, 1);
    check4("s2_no_repeat_at_release", bus.btns_repeat, 4'd0);
    cycles(3);

    // Direct change between buttons restarts the long timer.
    set_in(4'b0010);
    wait_evt("s3_press", 0, 4'b0010, 1);
    cycles(30);
    set_in(4'b1000);
    wait_evt("s3_press_new", 0, 4'b1000, 1);
    check4("s3_release_old", bus.btns_release, 4'b0010);
    wait_evt("s3_long", 2, 4'b1000, 200);
    set_in(4'b0000);
    wait_evt("s3_release", 1, 4'b1000, 1);
    cycles(3);

    // Invalid input locks until zero is seen.
    set_in(4'b0011);
    cycles(5);
    check4("s4_lock_held", bus.btns_held, 4'd0);
    set_in(4'b0001);
    cycles(5);
    check4("s4_lock_ignore", bus.btns_press, 4'd0);
    check4("s4_lock_held2", bus.btns_held, 4'd0);
    set_in(4'b0000);
    cycles(3);
    set_in(4'b0001);
    wait_evt("s4_press", 0, 4'b0001, 1);
    set_in(4'b0000);
    wait_evt("s4_release", 1, 4'b0001, 1);
    cycles(3);

    // Asynchronous reset mid-hold, then a fresh press with the button held.
    set_in(4'b0001);
    wait_evt("s5_press", 0, 4'b0001, 1);
    wait_evt("s5_long", 2, 4'b0001, 200);
    cycles(20);
    #2 rst = 1'b1;
    #1;
    check4("s5_async_held", bus.btns_held, 4'd0);
    check4("s5_async_press", bus.btns_press, 4'd0);
    check4("s5_async_release", bus.btns_release, 4'd0);
    cycles(3);
    rst = 1'b0;
    wait_evt("s5_press_after_reset", 0, 4'b0001, 1);
    set_in(4'b0000);
    wait_evt("s5_release", 1, 4'b0001, 1);
    cycles(3);

    // Random traffic: mostly one-hot, some zero/invalid, some long holds.
    for (int s = 0; s < 60; s++) begin
      seg_cls = $urandom_range(0, 9);
      if (seg_cls <= 2)      v = 4'd0;
      else if (seg_cls <= 8) v = 4'(1 << $urandom_range(0, 3));
      else begin
        v = 4'($urandom_range(0, 15));
        while ($countones(v) < 2) v = 4'($urandom_range(0, 15));
      end
      seg_len = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 450) : $urandom_range(1, 8);
      set_in(v);
      cycles(seg_len);
    end
    set_in(4'b0000);
    cycles(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
